// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_e;

  // cpol/cpha positions are offsets above the width field of the mode word
  localparam int CFG_CPOL_BIT = 1;
  localparam int CFG_CPHA_BIT = 0;

  function automatic int cfg_width(input int max_width_log);
    return max_width_log + 2;
  endfunction

endpackage

// File: rtl/spi_watchdog.sv
// Transfer watchdog: counts enabled cycles and flags the cycle whose count reaches the limit.
module spi_watchdog #(
  parameter int TIMEOUT_LOG = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic limit_o
);

  localparam logic [TIMEOUT_LOG-1:0] LIMIT = '1;

  logic [TIMEOUT_LOG-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High in the enabled cycle whose increment lands on the limit
  assign limit_o = enable_i && (count_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/spi_transfer_ctrl.sv
// Sequences single SPI transfers: optional mode reload, start strobe, watched wait, response.
module spi_transfer_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int TIMEOUT_LOG       = 16,
  localparam int DW = 2**SPI_MAX_WIDTH_LOG,
  localparam int CW = cfg_width(SPI_MAX_WIDTH_LOG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_cfg,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_timeout,
  output logic          config_req,
  output logic [CW-1:0] config_data,
  output logic          spi_start,
  input  logic          spi_finish,
  output logic [DW-1:0] spi_din,
  input  logic [DW-1:0] spi_dout,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] cur_cfg_q, cur_cfg_d;
  logic [CW-1:0] applied_cfg_q, applied_cfg_d;
  logic          cfg_loaded_q, cfg_loaded_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          wd_limit;

  always_comb begin
    state_d       = state_q;
    cur_cfg_d     = cur_cfg_q;
    applied_cfg_d = applied_cfg_q;
    cfg_loaded_d  = cfg_loaded_q;
    din_d         = din_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          cur_cfg_d = req_cfg;
          din_d     = req_data;
          state_d   = (!cfg_loaded_q || (req_cfg != applied_cfg_q)) ? ST_CONFIG : ST_START;
        end
      end
      ST_CONFIG: begin
        applied_cfg_d = cur_cfg_q;
        cfg_loaded_d  = 1'b1;
        state_d       = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A finish arriving on the limit cycle still counts as a completed transfer
        if (spi_finish) begin
          rsp_data_d    = spi_dout;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (wd_limit) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          cfg_loaded_d  = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_cfg_q     <= '0;
      applied_cfg_q <= '0;
      cfg_loaded_q  <= 1'b0;
      din_q         <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_cfg_q     <= cur_cfg_d;
      applied_cfg_q <= applied_cfg_d;
      cfg_loaded_q  <= cfg_loaded_d;
      din_q         <= din_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  spi_watchdog #(
    .TIMEOUT_LOG(TIMEOUT_LOG)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == ST_START),
    .enable_i(state_q == ST_WAIT),
    .limit_o (wd_limit)
  );

  assign req_ready   = rst_n && (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign config_req  = (state_q == ST_CONFIG);
  assign config_data = (state_q == ST_CONFIG) ? cur_cfg_q : applied_cfg_q;
  assign spi_start   = (state_q == ST_START);
  assign spi_din     = din_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/spi_transfer_ctrl.md
# spi_transfer_ctrl

Transaction sequencer placed directly upstream of the SPI master interface. Accepts one transfer request at a time (per-request mode word plus TX data) over a valid/ready handshake. Reprograms the master's mode only when it changes, pulses the transfer start, and waits for completion under a watchdog. Returns the received word, or a timeout flag, over a second valid/ready handshake.

## Interface
Parameters:
- SPI_MAX_WIDTH_LOG, 4, log2 of maximum word width; data width DW = 2**SPI_MAX_WIDTH_LOG
- TIMEOUT_LOG, 16, watchdog limit is 2**TIMEOUT_LOG-1 cycles in WAIT

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_cfg  in  SPI_MAX_WIDTH_LOG+2  mode word: [MSB]=cpol, [MSB-1]=cpha, [SPI_MAX_WIDTH_LOG-1:0]=width field (passed unchanged)
- req_data  in  DW  word to transmit
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  DW  received word (0 on timeout)
- rsp_timeout  out  1  transfer aborted by watchdog
- config_req  out  1  one-cycle mode-load strobe to master
- config_data  out  SPI_MAX_WIDTH_LOG+2  mode word to master
- spi_start  out  1  one-cycle transfer start strobe
- spi_finish  in  1  transfer-complete pulse from master
- spi_din  out  DW  TX word to master
- spi_dout  in  DW  RX word from master
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, CONFIG, START, WAIT, RESP.
- IDLE: req_ready = 1 (forced 0 while rst_n low). On req_valid&req_ready, register req_cfg → cur_cfg and req_data → spi_din.
  - Go to CONFIG if cfg_loaded==0 or cur_cfg != applied_cfg; otherwise go to START.
- CONFIG: config_req=1 for exactly one cycle with config_data=cur_cfg; applied_cfg←cur_cfg, cfg_loaded←1; → START.
- START: spi_start=1 for exactly one cycle; clear watchdog; → WAIT.
- WAIT: watchdog increments each cycle.
  - spi_finish=1: rsp_data←spi_dout, rsp_timeout←0; → RESP.
  - Watchdog reaches 2**TIMEOUT_LOG-1 without finish: rsp_data←0, rsp_timeout←1, cfg_loaded←0 (next request forces reconfig); → RESP.
  - spi_finish and limit in the same cycle: finish wins.
- RESP: rsp_valid=1, rsp_data/rsp_timeout stable until rsp_ready; on rsp_ready → IDLE.
- spi_finish outside WAIT is ignored.
- spi_din is held constant from acceptance until the next acceptance.
- config_data always drives applied_cfg, except during the CONFIG cycle, when it drives cur_cfg.

## Timing
- Reset (rst_n low at an edge): state=IDLE; req_ready, rsp_valid, rsp_timeout, config_req, spi_start, busy = 0; rsp_data, spi_din, config_data, applied_cfg = 0; cfg_loaded=0; watchdog=0.
  - Reset mid-transfer aborts without a response. Any in-flight master transfer is the master's concern.
- Accept at edge 0 → config_req high in cycle 1 (if needed) → spi_start high in cycle 1 (no config) or cycle 2 (config).
- spi_finish sampled high at edge N → rsp_valid high from cycle N+1.
- rsp_ready may already be high when rsp_valid rises; the handshake completes on that edge. req_ready is high the next cycle.
- Minimum request-to-request spacing: 4 cycles plus transfer time (no config); 5 cycles with config.
- Only one transfer is outstanding; no request buffering.

## Structure
- Shared package spi_pkg holds:
  - FSM state enum
  - cfg bit-index constants CFG_CPOL_BIT, CFG_CPHA_BIT
  - cfg field width function of SPI_MAX_WIDTH_LOG
- One sub-module, spi_watchdog: clear, enable and a limit-reached output; TIMEOUT_LOG-bit counter saturating at the limit.

## Test plan
- After reset, request cfg=6'b10_0111, data=16'hA5C3 → config_req one cycle with config_data=6'b10_0111, spi_start the next cycle. Model returns finish with dout=16'h3C5A → rsp_valid, rsp_data=16'h3C5A, rsp_timeout=0.
- Second request with the same cfg, data=16'h0001 → no config_req, spi_start one cycle after acceptance, response correct.
- Cfg change to 6'b01_1111 on a third request → config_req fires with the new word; spi_din=request data throughout.
- TIMEOUT_LOG=4, model never finishes → rsp_valid after 15 WAIT cycles with rsp_timeout=1, rsp_data=0. The next same-cfg request still issues config_req.
- Hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_data stable, req_ready=0, a spurious spi_finish is ignored. Raising rsp_ready → IDLE next cycle.
- Assert rst_n=0 for one cycle during WAIT → all outputs at reset values next cycle, no response. The next request forces config_req.
